// File: rtl/ram_ctrl_dp_if.sv
`default_nettype none
// ============================================================================
// Module  : ram_ctrl_dp_if
// Brief   : Write/read handshake bundle for the ram_ctrl_dp buffer.
// Revision: 1.0
// ============================================================================
interface ram_ctrl_dp_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
);
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_rdy;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_rdy;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  addr_err;
    logic                  init_done;
    logic                  rd_parity_err;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_rdy, rd_rdy, rd_valid, rd_data, addr_err, init_done, rd_parity_err
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_rdy, rd_rdy, rd_valid, rd_data, addr_err, init_done, rd_parity_err
    );
endinterface
`default_nettype wire

// File: rtl/ram_ctrl_dp.sv
`default_nettype none
// ============================================================================
// Module  : ram_ctrl_dp
// Brief   : Simple-dual-port RAM, valid/ready ports, post-reset clear sweep,
//           write-first forwarding. Optional stored parity: `define PARITY_EN.
// Revision: 1.0
// ============================================================================
module ram_ctrl_dp #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_DEPTH   = 512,
    parameter int                    ADDR_WIDTH   = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA = '0
) (
    input  logic         clk,
    input  logic         rst,
    ram_ctrl_dp_if.slave bus
);

`ifdef PARITY_EN
    localparam int c_mem_w = DATA_WIDTH + 1;
`else
    localparam int c_mem_w = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH:0]   c_depth = (ADDR_WIDTH+1)'(ADDR_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_last  = ADDR_WIDTH'(ADDR_DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;

    logic [c_mem_w-1:0]    r_mem [ADDR_DEPTH];

    logic                  w_run;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_wr_oor;
    logic                  w_rd_oor;
    logic                  w_collide;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_waddr;
    logic [c_mem_w-1:0]    w_mem_wdata;
    logic [ADDR_WIDTH-1:0] w_mem_raddr;
    logic [c_mem_w-1:0]    w_mem_rword;
    logic [DATA_WIDTH-1:0] w_rd_data_nxt;
    logic                  w_par_err_nxt;

    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_addr_err;
    logic                  r_par_err;

    // Stored word layout: {even-parity bit, data} when parity is enabled.
    function automatic logic [c_mem_w-1:0] f_encode(input logic [DATA_WIDTH-1:0] d);
`ifdef PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    assign w_run     = (r_state == S_RUN);
    assign w_wr_acc  = bus.wr_req & w_run;
    assign w_rd_acc  = bus.rd_req & w_run;
    assign w_wr_oor  = ({1'b0, bus.wr_addr} >= c_depth);
    assign w_rd_oor  = ({1'b0, bus.rd_addr} >= c_depth);
    assign w_collide = w_wr_acc & ~w_wr_oor & (bus.wr_addr == bus.rd_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // The single array write port is shared by the clear sweep and the user port.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_mem_we      = 1'b0;
        w_mem_waddr   = bus.wr_addr;
        w_mem_wdata   = f_encode(bus.wr_data);
        case (r_state)
            S_CLEAR: begin
                w_mem_we      = 1'b1;
                w_mem_waddr   = r_clr_cnt;
                w_mem_wdata   = f_encode(DEFAULT_DATA);
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == c_last) begin
                    w_state_nxt   = S_RUN;
                    w_clr_cnt_nxt = '0;
                end
            end
            S_RUN: begin
                w_mem_we = w_wr_acc & ~w_wr_oor;
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Out-of-range addresses never index the array; their data is substituted below.
    assign w_mem_raddr = w_rd_oor ? '0 : bus.rd_addr;
    assign w_mem_rword = r_mem[w_mem_raddr];

    always_comb begin
        w_rd_data_nxt = w_mem_rword[DATA_WIDTH-1:0];
        w_par_err_nxt = 1'b0;
        if (w_rd_oor) begin
            w_rd_data_nxt = DEFAULT_DATA;
        end else if (w_collide) begin
            w_rd_data_nxt = bus.wr_data;
        end
`ifdef PARITY_EN
        w_par_err_nxt = ~w_rd_oor & ~w_collide &
                        (w_mem_rword[DATA_WIDTH] ^ (^w_mem_rword[DATA_WIDTH-1:0]));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= DEFAULT_DATA;
            r_addr_err <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            r_addr_err <= (w_wr_acc & w_wr_oor) | (w_rd_acc & w_rd_oor);
            r_par_err  <= w_rd_acc & w_par_err_nxt;
            if (w_rd_acc) begin
                r_rd_data <= w_rd_data_nxt;
            end
        end
    end

    assign bus.wr_rdy        = w_run;
    assign bus.rd_rdy        = w_run;
    assign bus.init_done     = w_run;
    assign bus.rd_valid      = r_rd_valid;
    assign bus.rd_data       = r_rd_data;
    assign bus.addr_err      = r_addr_err;
    assign bus.rd_parity_err = r_par_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_ctrl_dp.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_ctrl_dp
// Brief   : Self-checking bench for ram_ctrl_dp (512-word and 300-word builds).
// Revision: 1.0
// ============================================================================
module tb_ram_ctrl_dp;
    localparam int         DW      = 8;
    localparam int         AW      = 9;
    localparam int         DEPTH_A = 512;
    localparam int         DEPTH_B = 300;
    localparam logic [7:0] DEF_A   = 8'hA5;
    localparam logic [7:0] DEF_B   = 8'h3E;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0] ma [DEPTH_A];
    logic [7:0] mb [DEPTH_B];

    ram_ctrl_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
    ram_ctrl_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

    ram_ctrl_dp #(.DATA_WIDTH(DW), .ADDR_DEPTH(DEPTH_A), .DEFAULT_DATA(DEF_A)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    ram_ctrl_dp #(.DATA_WIDTH(DW), .ADDR_DEPTH(DEPTH_B), .DEFAULT_DATA(DEF_B)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifa.wr_req = 1'b0; ifa.rd_req = 1'b0; ifa.wr_addr = '0; ifa.rd_addr = '0; ifa.wr_data = '0;
        ifb.wr_req = 1'b0; ifb.rd_req = 1'b0; ifb.wr_addr = '0; ifb.rd_addr = '0; ifb.wr_data = '0;
    endtask

    task automatic reset_models();
        for (int i = 0; i < DEPTH_A; i++) ma[i] = DEF_A;
        for (int i = 0; i < DEPTH_B; i++) mb[i] = DEF_B;
    endtask

    // Release reset and count cycles to init_done while hammering port A with requests.
    task automatic run_sweep(input string tag);
        int n, nb, vbad;
        n = 0; nb = -1; vbad = 0;
        rst = 1'b0;
        while (n < 1000) begin
            ifa.rd_req  = 1'b1;
            ifa.rd_addr = 9'($urandom_range(0, DEPTH_A - 1));
            ifa.wr_req  = 1'b1;
            ifa.wr_addr = 9'($urandom_range(0, DEPTH_A - 1));
            ifa.wr_data = 8'($urandom);
            tick();
            n++;
            if (ifa.rd_valid !== 1'b0 || (!ifa.init_done && (ifa.wr_rdy !== 1'b0 || ifa.rd_rdy !== 1'b0)))
                vbad++;
            if (nb < 0 && ifb.init_done === 1'b1) nb = n;
            if (ifa.init_done === 1'b1) break;
        end
        idle();
        n_cmp++;
        if (n !== DEPTH_A) begin
            n_err++;
            $display("FAIL %s_init_cycles_a: got %0d want %0d", tag, n, DEPTH_A);
        end
        n_cmp++;
        if (nb !== DEPTH_B) begin
            n_err++;
            $display("FAIL %s_init_cycles_b: got %0d want %0d", tag, nb, DEPTH_B);
        end
        n_cmp++;
        if (vbad !== 0) begin
            n_err++;
            $display("FAIL %s_no_service_in_sweep: got %0d bad cycles want 0", tag, vbad);
        end
        reset_models();
    endtask

    task automatic test_reset();
        idle();
        tick(); tick();
        n_cmp++;
        if ({ifa.wr_rdy, ifa.rd_rdy, ifa.rd_valid, ifa.addr_err, ifa.init_done, ifa.rd_parity_err, ifa.rd_data}
            !== {6'b0, DEF_A}) begin
            n_err++;
            $display("FAIL reset_a: got rdy%b%b v%b e%b d%b p%b data %h want all 0 data %h",
                     ifa.wr_rdy, ifa.rd_rdy, ifa.rd_valid, ifa.addr_err, ifa.init_done,
                     ifa.rd_parity_err, ifa.rd_data, DEF_A);
        end
        n_cmp++;
        if ({ifb.wr_rdy, ifb.rd_rdy, ifb.rd_valid, ifb.addr_err, ifb.init_done, ifb.rd_data}
            !== {5'b0, DEF_B}) begin
            n_err++;
            $display("FAIL reset_b: got data %h init %b want data %h init 0", ifb.rd_data, ifb.init_done, DEF_B);
        end
    endtask

    task automatic test_sweep();
        logic [8:0] addrs [3];
        run_sweep("sweep");
        addrs[0] = 9'd0; addrs[1] = 9'd255; addrs[2] = 9'd511;
        for (int i = 0; i < 3; i++) begin
            ifa.rd_req = 1'b1; ifa.rd_addr = addrs[i];
            tick();
            n_cmp++;
            if (ifa.rd_valid !== 1'b1 || ifa.rd_data !== DEF_A) begin
                n_err++;
                $display("FAIL sweep_read@%0d: got v%b %h want v1 %h", addrs[i], ifa.rd_valid, ifa.rd_data, DEF_A);
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        ifa.wr_req = 1'b1; ifa.wr_addr = 9'd27; ifa.wr_data = 8'h3C;
        tick();
        idle();
        ma[27] = 8'h3C;
        n_cmp++;
        if (ifa.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wr_only_no_valid: got %b want 0", ifa.rd_valid);
        end
        ifa.rd_req = 1'b1; ifa.rd_addr = 9'd27;
        tick();
        idle();
        n_cmp++;
        if (ifa.rd_valid !== 1'b1 || ifa.rd_data !== 8'h3C) begin
            n_err++;
            $display("FAIL write_then_read: got v%b %h want v1 3c", ifa.rd_valid, ifa.rd_data);
        end
        tick();
        n_cmp++;
        if (ifa.rd_valid !== 1'b0 || ifa.rd_data !== 8'h3C) begin
            n_err++;
            $display("FAIL read_hold: got v%b %h want v0 3c", ifa.rd_valid, ifa.rd_data);
        end
    endtask

    task automatic test_collision();
        ifa.wr_req = 1'b1; ifa.wr_addr = 9'd2; ifa.wr_data = 8'h5A;
        ifa.rd_req = 1'b1; ifa.rd_addr = 9'd2;
        tick();
        idle();
        ma[2] = 8'h5A;
        n_cmp++;
        if (ifa.rd_valid !== 1'b1 || ifa.rd_data !== 8'h5A || ifa.rd_parity_err !== 1'b0) begin
            n_err++;
            $display("FAIL collision_fwd: got v%b %h p%b want v1 5a p0", ifa.rd_valid, ifa.rd_data, ifa.rd_parity_err);
        end
    endtask

    task automatic test_out_of_range();
        int bad;
        ifb.wr_req = 1'b1; ifb.wr_addr = 9'd310; ifb.wr_data = 8'hFF;
        tick();
        idle();
        n_cmp++;
        if (ifb.addr_err !== 1'b1 || ifb.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL oor_write_err: got e%b v%b want e1 v0", ifb.addr_err, ifb.rd_valid);
        end
        ifb.rd_req = 1'b1; ifb.rd_addr = 9'd310;
        tick();
        idle();
        n_cmp++;
        if (ifb.addr_err !== 1'b1 || ifb.rd_valid !== 1'b1 || ifb.rd_data !== DEF_B) begin
            n_err++;
            $display("FAIL oor_read: got e%b v%b %h want e1 v1 %h", ifb.addr_err, ifb.rd_valid, ifb.rd_data, DEF_B);
        end
        ifb.wr_req = 1'b1; ifb.wr_addr = 9'd400; ifb.wr_data = 8'h11;
        ifb.rd_req = 1'b1; ifb.rd_addr = 9'd450;
        tick();
        idle();
        tick();
        n_cmp++;
        if (ifb.addr_err !== 1'b0 || ifb.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL oor_single_pulse: got e%b v%b want e0 v0", ifb.addr_err, ifb.rd_valid);
        end
        bad = 0;
        for (int i = 0; i < DEPTH_B; i++) begin
            ifb.rd_req = 1'b1; ifb.rd_addr = 9'(i);
            tick();
            if (ifb.rd_valid !== 1'b1 || ifb.rd_data !== mb[i] || ifb.addr_err !== 1'b0) bad++;
        end
        idle();
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL oor_mem_unchanged: got %0d bad words want 0", bad);
        end
    endtask

    task automatic test_random();
        logic       wa_r, ra_r, wb_r, rb_r;
        logic [8:0] waa, raa, wab, rab;
        logic [7:0] wda, wdb, exp_a, exp_b;
        logic       err_b;
        exp_a = ma[0];
        exp_b = mb[0];
        ifa.rd_req = 1'b1; ifa.rd_addr = '0;
        ifb.rd_req = 1'b1; ifb.rd_addr = '0;
        tick();
        idle();
        for (int c = 0; c < 500; c++) begin
            wa_r = 1'($urandom); ra_r = 1'($urandom);
            waa  = 9'($urandom_range(0, DEPTH_A - 1));
            raa  = ($urandom_range(0, 3) == 0) ? waa : 9'($urandom_range(0, DEPTH_A - 1));
            wda  = 8'($urandom);
            wb_r = 1'($urandom); rb_r = 1'($urandom);
            wab  = 9'($urandom_range(0, 511));
            rab  = ($urandom_range(0, 3) == 0) ? wab : 9'($urandom_range(0, 511));
            wdb  = 8'($urandom);
            ifa.wr_req = wa_r; ifa.wr_addr = waa; ifa.wr_data = wda; ifa.rd_req = ra_r; ifa.rd_addr = raa;
            ifb.wr_req = wb_r; ifb.wr_addr = wab; ifb.wr_data = wdb; ifb.rd_req = rb_r; ifb.rd_addr = rab;
            // Reference: reads see the same-cycle write; out-of-range reads return the default.
            if (ra_r) exp_a = (wa_r && waa == raa) ? wda : ma[raa];
            if (wa_r) ma[waa] = wda;
            if (rb_r) begin
                if (rab >= DEPTH_B)                exp_b = DEF_B;
                else if (wb_r && wab == rab)       exp_b = wdb;
                else                               exp_b = mb[rab];
            end
            err_b = (wb_r && wab >= DEPTH_B) || (rb_r && rab >= DEPTH_B);
            if (wb_r && wab < DEPTH_B) mb[wab] = wdb;
            tick();
            n_cmp++;
            if ({ifa.rd_valid, ifa.rd_data, ifa.addr_err, ifa.rd_parity_err} !== {ra_r, exp_a, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL random_a[%0d]: got v%b %h e%b p%b want v%b %h e0 p0", c,
                         ifa.rd_valid, ifa.rd_data, ifa.addr_err, ifa.rd_parity_err, ra_r, exp_a);
            end
            n_cmp++;
            if ({ifb.rd_valid, ifb.rd_data, ifb.addr_err} !== {rb_r, exp_b, err_b}) begin
                n_err++;
                $display("FAIL random_b[%0d]: got v%b %h e%b want v%b %h e%b", c,
                         ifb.rd_valid, ifb.rd_data, ifb.addr_err, rb_r, exp_b, err_b);
            end
        end
        idle();
    endtask

    task automatic test_reset_midsweep();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (ifa.init_done !== 1'b0 || ifa.rd_data !== DEF_A) begin
            n_err++;
            $display("FAIL midsweep_reset: got init %b data %h want init 0 data %h", ifa.init_done, ifa.rd_data, DEF_A);
        end
        run_sweep("midsweep");
        for (int i = 0; i < 2; i++) begin
            ifa.rd_req = 1'b1; ifa.rd_addr = (i == 0) ? 9'd27 : 9'd2;
            tick();
            n_cmp++;
            if (ifa.rd_valid !== 1'b1 || ifa.rd_data !== DEF_A) begin
                n_err++;
                $display("FAIL midsweep_cleared[%0d]: got v%b %h want v1 %h", i, ifa.rd_valid, ifa.rd_data, DEF_A);
            end
        end
        idle();
    endtask

    task automatic test_parity();
        ifa.wr_req = 1'b1; ifa.wr_addr = 9'd9; ifa.wr_data = 8'h6B;
        tick();
        idle();
`ifdef PARITY_EN
        dut_a.r_mem[9] = dut_a.r_mem[9] ^ 9'h001;
        ifa.rd_req = 1'b1; ifa.rd_addr = 9'd9;
        tick();
        idle();
        n_cmp++;
        if (ifa.rd_valid !== 1'b1 || ifa.rd_parity_err !== 1'b1) begin
            n_err++;
            $display("FAIL parity_flip: got v%b p%b want v1 p1", ifa.rd_valid, ifa.rd_parity_err);
        end
`else
        ifa.rd_req = 1'b1; ifa.rd_addr = 9'd9;
        tick();
        idle();
        n_cmp++;
        if (ifa.rd_valid !== 1'b1 || ifa.rd_data !== 8'h6B || ifa.rd_parity_err !== 1'b0) begin
            n_err++;
            $display("FAIL parity_off: got v%b %h p%b want v1 6b p0", ifa.rd_valid, ifa.rd_data, ifa.rd_parity_err);
        end
`endif
    endtask

    initial begin
        idle();
        test_reset();
        test_sweep();
        test_write_read();
        test_collision();
        test_out_of_range();
        test_random();
        test_reset_midsweep();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
